// File: rtl/cnn1d_pkg.sv
// Shared types and defaults for the 1-D CNN pipeline blocks.
package cnn1d_pkg;

  // Default geometry of the global-average-pool drain path.
  localparam int GAVG_DATA_WIDTH_DEF = 12;
  localparam int GAVG_NUM_POOLS_DEF  = 32;

  // Serialiser control state: waiting for a channel set, or replaying it.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } gavgpool_ser_state_t;

endpackage : cnn1d_pkg

// File: rtl/gavgpool_serialiser.sv
// Global-average-pool drain controller: captures all pooled channel values in
// one upstream handshake, then replays them one channel per beat onto a single
// serial stream tagged with channel index and a last flag.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holding valid=1 keeps its data stable
// until that transfer. Upstream counts as "valid" only when every per-channel
// valid bit is set; a partial set is never taken.
module gavgpool_serialiser
  import cnn1d_pkg::*;
#(
  parameter  int DATA_WIDTH = GAVG_DATA_WIDTH_DEF,
  parameter  int NUM_POOLS  = GAVG_NUM_POOLS_DEF,
  localparam int IDX_WIDTH  = $clog2(NUM_POOLS)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ser_ready_in,
  input  logic [NUM_POOLS-1:0]      ser_valid_in,
  input  logic [DATA_WIDTH-1:0]     ser_data_in [0:NUM_POOLS-1],
  input  logic                      ser_ready_out,
  output logic                      ser_valid_out,
  output logic [DATA_WIDTH-1:0]     ser_data_out,
  output logic [IDX_WIDTH-1:0]      ser_index_out,
  output logic                      ser_last_out,
  output gavgpool_ser_state_t       ser_dbg_state_out
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_POOLS - 1);

  gavgpool_ser_state_t         state_q, state_d;
  logic [IDX_WIDTH-1:0]        idx_q, idx_d;
  logic                        ready_q, ready_d;
  logic [DATA_WIDTH-1:0]       bank_q [0:NUM_POOLS-1];
  logic                        capture;
  logic                        at_last;

  assign at_last = (idx_q == LAST_IDX);

  // Next-state logic: capture a full channel set in IDLE, step the index on
  // every accepted beat in DRAIN, and fall back to IDLE after the last beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && (&ser_valid_in)) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ser_ready_out) begin
          if (at_last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    // Registered so the upstream ready has no path from any input.
    ready_d = (state_d == IDLE);
  end

  // State, index and upstream-ready registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Channel register bank: written only on capture, so it is never disturbed
  // while a frame is draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_POOLS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_POOLS; i++) begin
        bank_q[i] <= ser_data_in[i];
      end
    end
  end

  // Serial outputs are decoded from registered state only; data and flags are
  // forced to zero outside DRAIN so the idle bus is quiet.
  always_comb begin
    ser_valid_out = (state_q == DRAIN);
    ser_data_out  = '0;
    ser_last_out  = 1'b0;
    if (state_q == DRAIN) begin
      ser_data_out = bank_q[idx_q];
      ser_last_out = at_last;
    end
  end

  assign ser_index_out     = idx_q;
  assign ser_ready_in      = ready_q;
  assign ser_dbg_state_out = state_q;

endmodule : gavgpool_serialiser

// File: tb/tb_gavgpool_serialiser.sv
// Directed bench for gavgpool_serialiser with NUM_POOLS=4, DATA_WIDTH=12.
module tb_gavgpool_serialiser;
  import cnn1d_pkg::*;

  localparam int DW = 12;
  localparam int NP = 4;
  localparam int IW = 2;
  localparam int EW = DW + IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                ser_ready_in;
  logic [NP-1:0]       ser_valid_in;
  logic [DW-1:0]       ser_data_in [0:NP-1];
  logic                ser_ready_out;
  logic                ser_valid_out;
  logic [DW-1:0]       ser_data_out;
  logic [IW-1:0]       ser_index_out;
  logic                ser_last_out;
  gavgpool_ser_state_t ser_dbg_state_out;

  gavgpool_serialiser #(.DATA_WIDTH(DW), .NUM_POOLS(NP)) dut (
    .clk              (clk),
    .rst              (rst),
    .ser_ready_in     (ser_ready_in),
    .ser_valid_in     (ser_valid_in),
    .ser_data_in      (ser_data_in),
    .ser_ready_out    (ser_ready_out),
    .ser_valid_out    (ser_valid_out),
    .ser_data_out     (ser_data_out),
    .ser_index_out    (ser_index_out),
    .ser_last_out     (ser_last_out),
    .ser_dbg_state_out(ser_dbg_state_out)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {last, index, data}
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cap_count = 0;
  int cap_cyc[$];
  int beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: predict captures from the stimulus side and
  // pop the expected beat whenever the DUT is about to transfer one.
  always @(negedge clk) begin
    if (rst) begin
      if (ser_ready_in && (&ser_valid_in)) begin
        cap_count++;
        cap_cyc.push_back(cyc);
        for (int i = 0; i < NP; i++)
          exp_q.push_back({(i == NP - 1), IW'(i), ser_data_in[i]});
      end
      if (ser_valid_out && ser_ready_out) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(ser_index_out), 32'hFFFF);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", 32'(ser_data_out), 32'(e[DW-1:0]));
          check("beat_index", 32'(ser_index_out), 32'(e[DW+IW-1:DW]));
          check("beat_last", 32'(ser_last_out), 32'(e[EW-1]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [DW-1:0] a, b, c, d);
    ser_data_in[0] = a;
    ser_data_in[1] = b;
    ser_data_in[2] = c;
    ser_data_in[3] = d;
  endtask

  // Raise all valids and return in the cycle right after the capture edge.
  task automatic send_frame(input logic [DW-1:0] a, b, c, d, input bit hold_valid);
    int c0;
    int n;
    c0 = cap_count;
    n = 0;
    set_data(a, b, c, d);
    ser_valid_in = '1;
    while (cap_count == c0 && n < 30) begin
      step();
      n++;
    end
    if (cap_count == c0) check("capture_timeout", 32'(n), 32'(0));
    if (!hold_valid) ser_valid_in = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(ser_ready_in && exp_q.size() == 0) && n < 100) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready_in"},  32'(ser_ready_in),  32'(0));
    check({tag, "_valid_out"}, 32'(ser_valid_out), 32'(0));
    check({tag, "_data_out"},  32'(ser_data_out),  32'(0));
    check({tag, "_index_out"}, 32'(ser_index_out), 32'(0));
    check({tag, "_last_out"},  32'(ser_last_out),  32'(0));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b0;
    ser_valid_in  = '1;
    ser_ready_out = 1'b1;
    set_data(12'h011, 12'h022, 12'h033, 12'h044);

    // Reset held with all valids high: outputs stay clear, nothing captured.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs_zero("reset");
    end
    check("reset_no_capture", 32'(cap_count), 32'(0));
    check("reset_state", 32'(ser_dbg_state_out), 32'(IDLE));

    // Release: ready_in rises on the first edge.
    @(posedge clk);
    #1;
    rst = 1'b1;
    ser_valid_in = '0;
    check("release_ready_low", 32'(ser_ready_in), 32'(0));
    step();
    check("release_ready_high", 32'(ser_ready_in), 32'(1));

    // Full drain with no stall: 4 consecutive beats, ready back one cycle later.
    b0 = beats;
    send_frame(12'h011, 12'h022, 12'h033, 12'h044, 1'b0);
    check("drain_first_valid", 32'(ser_valid_out), 32'(1));
    check("drain_first_index", 32'(ser_index_out), 32'(0));
    check("drain_first_data", 32'(ser_data_out), 32'h011);
    check("drain_ready_low", 32'(ser_ready_in), 32'(0));
    repeat (NP) step();
    check("drain_beats", 32'(beats - b0), 32'(NP));
    check("drain_q_empty", 32'(exp_q.size()), 32'(0));
    check("drain_ready_back", 32'(ser_ready_in), 32'(1));
    check("drain_valid_done", 32'(ser_valid_out), 32'(0));

    // Backpressure on index 1 for 5 cycles.
    b0 = beats;
    send_frame(12'h011, 12'h022, 12'h033, 12'h044, 1'b0);
    step();
    ser_ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(ser_valid_out), 32'(1));
      check("stall_data", 32'(ser_data_out), 32'h022);
      check("stall_index", 32'(ser_index_out), 32'(1));
      check("stall_last", 32'(ser_last_out), 32'(0));
      step();
    end
    ser_ready_out = 1'b1;
    check("resume_index", 32'(ser_index_out), 32'(1));
    wait_idle("stall_drain_done");
    check("stall_beats", 32'(beats - b0), 32'(NP));

    // Partial valid for 10 cycles: no capture, ready stays high.
    set_data(12'h5A5, 12'h0F0, 12'h123, 12'hABC);
    ser_valid_in = 4'b1011;
    b0 = cap_count;
    for (int i = 0; i < 10; i++) begin
      step();
      check("partial_ready", 32'(ser_ready_in), 32'(1));
      check("partial_valid_out", 32'(ser_valid_out), 32'(0));
    end
    check("partial_no_capture", 32'(cap_count - b0), 32'(0));
    ser_valid_in = 4'b1111;
    step();
    check("partial_then_capture", 32'(cap_count - b0), 32'(1));
    check("partial_capture_valid", 32'(ser_valid_out), 32'(1));
    ser_valid_in = '0;
    wait_idle("partial_drain_done");

    // Inputs change during drain: captured values must still come out.
    b0 = beats;
    send_frame(12'h101, 12'h202, 12'h303, 12'h404, 1'b0);
    step();
    set_data(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    ser_valid_in = '1;
    step();
    check("change_index", 32'(ser_index_out), 32'(2));
    check("change_data", 32'(ser_data_out), 32'h303);
    ser_valid_in = '0;
    wait_idle("change_drain_done");
    check("change_beats", 32'(beats - b0), 32'(NP));

    // Reset while index 2 is presented: outputs clear at once, beats dropped.
    send_frame(12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4, 1'b0);
    step();
    step();
    check("midrst_index", 32'(ser_index_out), 32'(2));
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("midrst");
    step();
    rst = 1'b1;

    // Two back-to-back frames with valids held high throughout.
    b0 = beats;
    cap_cyc.delete();
    send_frame(12'h111, 12'h222, 12'h333, 12'h444, 1'b1);
    set_data(12'h765, 12'h876, 12'h987, 12'hA98);
    send_frame(12'h765, 12'h876, 12'h987, 12'hA98, 1'b0);
    wait_idle("b2b_drain_done");
    check("b2b_beats", 32'(beats - b0), 32'(2 * NP));
    check("b2b_captures", 32'(cap_cyc.size()), 32'(2));
    if (cap_cyc.size() == 2)
      check("b2b_period", 32'(cap_cyc[1] - cap_cyc[0]), 32'(NP + 1));

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gavgpool_serialiser

// File: doc/gavgpool_serialiser.md
# gavgpool_serialiser

Drain controller for the global-average-pool layer. It captures all NUM_POOLS pooled channel results in one handshake and replays them one channel per beat onto a single valid/ready stream, tagged with channel index and last flag. The downstream classifier can therefore share one datapath across all channels. It sits between the pool layer's parallel output and the dense layer's serial input. Its upstream ready drives the pool layer's shared output ready.

## Interface
- DATA_WIDTH, 12, width of each pooled value
- NUM_POOLS, 32, number of parallel pool channels (≥2)
- IDX_WIDTH, $clog2(NUM_POOLS), channel-index width (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- ser_ready_in  output  1  ready to capture a full channel set
- ser_valid_in  input  NUM_POOLS  per-channel valid from pool layer
- ser_data_in  input  DATA_WIDTH × [0:NUM_POOLS-1]  per-channel pooled values
- ser_ready_out  input  1  downstream ready
- ser_valid_out  output  1  serial beat valid
- ser_data_out  output  DATA_WIDTH  current channel value
- ser_index_out  output  IDX_WIDTH  channel number of current beat
- ser_last_out  output  1  high on channel NUM_POOLS-1 beat

## Operation
- FSM has two states.
  - IDLE: waiting for a channel set.
  - DRAIN: emitting beats.
- Capture:
  - In IDLE, a capture occurs on the edge where ser_ready_in=1 and &ser_valid_in=1.
  - On capture, all NUM_POOLS values are written into a register bank, idx←0, and state→DRAIN.
- Partial valid (some but not all bits set) is never a capture.
  - The block keeps waiting with ser_ready_in=1.
  - No data is taken.
  - The upstream must hold its valids per valid/ready rules.
- DRAIN behaviour:
  - ser_valid_out=1.
  - ser_data_out=bank[idx], ser_index_out=idx.
  - ser_last_out=(idx==NUM_POOLS-1).
- A beat is transferred on an edge with ser_valid_out&ser_ready_out.
  - Non-last beat: idx←idx+1.
  - Last beat: idx←0 and state→IDLE.
- Stall: while ser_valid_out=1 and ser_ready_out=0, ser_data_out, ser_index_out and ser_last_out hold stable.
- ser_valid_in is ignored in DRAIN. The bank is never overwritten mid-drain.
- No arithmetic on data; values pass through bit-exact.

## Timing
- Reset values (while rst=0, asynchronously):
  - state=IDLE, idx=0, bank cleared to 0.
  - ser_ready_in=0, ser_valid_out=0, ser_data_out=0, ser_index_out=0, ser_last_out=0.
- ser_ready_in is a flop whose next value is (next_state==IDLE). After rst deasserts it rises on the first clk edge.
- ser_valid_out is high exactly in DRAIN, decoded from the state flop.
- No combinational path exists from any input to ser_ready_in or ser_valid_out.
- Latency and throughput:
  - Capture on edge t gives ser_valid_out=1 with channel 0 from cycle t+1.
  - With ser_ready_out held 1, beats for channels 0..NUM_POOLS-1 occupy cycles t+1..t+NUM_POOLS.
  - ser_ready_in returns to 1 in cycle t+NUM_POOLS+1.
  - Minimum frame period is NUM_POOLS+1 cycles.
- Reset asserted mid-drain: the remaining beats are dropped, outputs go to reset values immediately, and the next capture starts a fresh frame.

## Structure
- Add to cnn1d_pkg the state typedef gavgpool_ser_state_t, an enum with IDLE and DRAIN.
- Register bank, index counter and FSM are inline; no sub-module.
- Intended instantiation: directly downstream of the pool layer, with ser_ready_in wired to the pool layer's shared output ready.

## Test plan
- Reset/bring-up:
  - Stimulus: hold rst=0 for 3 cycles with all ser_valid_in=1.
  - Required: all outputs 0, no capture.
  - After release: ser_ready_in=1 on the first edge.
- Full drain, no stall:
  - Stimulus: NUM_POOLS=4, inputs {0x011,0x022,0x033,0x044}, ser_ready_out=1.
  - Required: beats 0x011/0, 0x022/1, 0x033/2, 0x044/3 in consecutive cycles, ser_last_out only on index 3, ser_ready_in back to 1 one cycle later.
- Backpressure:
  - Stimulus: drop ser_ready_out for 5 cycles while index 1 is presented.
  - Required: data 0x022, index 1 and valid held stable; drain resumes at index 2 with no beat lost or duplicated.
- Partial valid:
  - Stimulus: ser_valid_in=4'b1011 for 10 cycles, then 4'b1111.
  - Required: no capture for 10 cycles with ready_in staying 1; capture on the first all-valid edge.
- Input change during drain:
  - Stimulus: change ser_data_in to {0xFFF…} mid-drain.
  - Required: the remaining beats still carry the captured values.
- Reset mid-drain and back-to-back frames:
  - Stimulus: assert rst at index 2, release, then feed two consecutive frames.
  - Required: immediate output clear; each frame is emitted completely; captures are exactly 5 cycles apart (NUM_POOLS=4).
